run_detect_ctrl: RTL and testbench

//   Bit-serial scheduler for the run-length sequence detector. Accepts parallel

---
 rtl/seqdet_pkg.sv | 21 ++
 rtl/run_detector.sv | 47 ++++
 rtl/run_detect_ctrl.sv | 148 ++++++++++++++
 tb/tb_run_detect_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared types and defaults for the run-length sequence detector slice.
// Provides the controller state encoding and default word / run lengths,
// plus a helper for sizing counters that must hold values 0..n inclusive.
package seqdet_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_RUN_LEN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed to represent every value from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/run_detector.sv
// Moore run-length detector: z is high while the last RUN_LEN fed bits were identical.
// Ports: clk, rst (async, active-low), en (feed bit_in this edge), bit_in,
//        clr (drop run history, wins over en), z (registered, one cycle after the feed).
module run_detector
  import seqdet_pkg::*;
#(
  parameter int RUN_LEN = DEF_RUN_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic bit_in,
  input  logic clr,
  output logic z
);

  localparam int                LEN_W   = cnt_width(RUN_LEN);
  localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(RUN_LEN);
  localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);

  logic [LEN_W-1:0] run_len;
  logic             last_bit;

  // run_len==0 means "no history": the next fed bit always starts a run of 1,
  // whatever last_bit holds, so clr does not need to touch last_bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_len  <= '0;
      last_bit <= 1'b0;
    end else if (clr) begin
      run_len  <= '0;
    end else if (en) begin
      last_bit <= bit_in;
      if ((run_len != '0) && (bit_in == last_bit)) begin
        // Saturate so long runs keep z asserted without wrapping.
        if (run_len != LEN_MAX) begin
          run_len <= run_len + LEN_ONE;
        end
      end else begin
        run_len <= LEN_ONE;
      end
    end
  end

  assign z = (run_len == LEN_MAX);

endmodule

// File: rtl/run_detect_ctrl.sv
// Bit-serial scheduler: accepts a word, feeds it LSB-first into run_detector
// one bit per clock, counts detector hits and returns the count.
// Ports: clk, rst (async, active-low); in_valid/in_ready/in_data/in_clr word side;
//        out_valid/out_ready/out_hits/out_last_z result side; busy = not IDLE.
module run_detect_ctrl
  import seqdet_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RUN_LEN = DEF_RUN_LEN,
  parameter int CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_hits,
  output logic              out_last_z,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  hits;
  logic              accept;
  logic              en;
  logic              en_d;
  logic              det_clr;
  logic              z;
  logic              last_z;

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    det_clr   = 1'b0;
    en        = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          // History is cleared on the accept edge so the first fed bit
          // already starts a fresh run.
          det_clr   = in_clr;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        en = 1'b1;
        if (bit_cnt == LAST_IDX) begin
          state_nxt = DRAIN;
        end
      end
      // z for the last bit only becomes visible here; give the hit counter
      // one cycle to see it before presenting the result.
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shreg   <= in_data;
      bit_cnt <= '0;
    end else if (en) begin
      shreg   <= shreg >> 1;
      bit_cnt <= bit_cnt + CNT_ONE;
    end
  end

  // z is Moore, so a hit for the bit fed at edge k is counted at edge k+1;
  // en_d lines that up and lets the DRAIN cycle pick up the last bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_d <= 1'b0;
      hits <= '0;
    end else begin
      en_d <= en;
      if (accept) begin
        hits <= '0;
      end else if (en_d && z) begin
        hits <= hits + CNT_ONE;
      end
    end
  end

  // Snapshot z after the last bit so a later in_clr on the next accept
  // cannot disturb the value still on offer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_z <= 1'b0;
    end else if (state == DRAIN) begin
      last_z <= z;
    end
  end

  run_detector #(
    .RUN_LEN (RUN_LEN)
  ) u_det (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .bit_in (shreg[0]),
    .clr    (det_clr),
    .z      (z)
  );

  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_hits   = hits;
  assign out_last_z = last_z;

endmodule

// File: tb/tb_run_detect_ctrl.sv
module tb_run_detect_ctrl;

  localparam int DATA_W  = 8;
  localparam int RUN_LEN = 4;
  localparam int CNT_W   = $clog2(DATA_W + 1);

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_clr;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_hits;
  logic              out_last_z;
  logic              busy;

  run_detect_ctrl #(
    .DATA_W  (DATA_W),
    .RUN_LEN (RUN_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_clr     (in_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hits   (out_hits),
    .out_last_z (out_last_z),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       clr;
    int         hits;
    logic       last_z;
  } vec_t;

  typedef struct {
    int   hits;
    logic last_z;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_pushed = 0;
  int   n_popped = 0;
  exp_t sb[$];
  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every result handshake pops the oldest expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got out_valid with hits=%0d, expected no result", out_hits);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_popped++;
        check("out_hits", int'(out_hits), e.hits);
        check("out_last_z", int'(out_last_z), int'(e.last_z));
      end
    end
  end

  task automatic drive(input vec_t v, input bit push);
    exp_t e;
    in_valid = 1'b1;
    in_data  = v.data;
    in_clr   = v.clr;
    if (push) begin
      e.hits   = v.hits;
      e.last_z = v.last_z;
      sb.push_back(e);
      n_pushed++;
    end
  endtask

  // Returns #1 after the edge on which the offered word was taken.
  task automatic wait_accept(output int acc_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    check("accept_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic send(input vec_t v, input bit push, output int acc_cyc);
    @(posedge clk);
    #1;
    drive(v, push);
    wait_accept(acc_cyc);
    in_valid = 1'b0;
    in_clr   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_sb_empty", sb.size(), 0);
    check("drain_idle", int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_hits"}, int'(out_hits), 0);
    check({tag, "_out_last_z"}, int'(out_last_z), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int   acc;
    int   prev;
    int   n;
    vec_t v;

    vecs[0] = '{8'h00, 1'b1, 5, 1'b1};
    vecs[1] = '{8'h0F, 1'b1, 2, 1'b1};
    vecs[2] = '{8'h55, 1'b1, 0, 1'b0};
    vecs[3] = '{8'hF0, 1'b1, 2, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 8, 1'b1};
    vecs[5] = '{8'hF0, 1'b1, 2, 1'b1};
    vecs[6] = '{8'hFF, 1'b1, 5, 1'b1};

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_clr    = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Table: one word at a time, first one also times the latency.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i], 1'b1, acc);
      if (i == 0) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 40);
        check("latency_cycles", n, 10);
      end
      drain();
    end

    // Back-to-back with in_valid held high.
    @(posedge clk);
    #1;
    drive(vecs[0], 1'b1);
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      wait_accept(acc);
      if (i > 0) check("b2b_interval", acc - prev, 11);
      prev = acc;
      if (i < 6) begin
        drive(vecs[i + 1], 1'b1);
      end else begin
        in_valid = 1'b0;
        in_clr   = 1'b0;
      end
    end
    drain();
    check("b2b_count", n_popped, n_pushed);

    // Result held under backpressure; a pending word must wait.
    out_ready = 1'b0;
    v = '{8'h00, 1'b1, 5, 1'b1};
    send(v, 1'b1, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    check("bp_reach_done", int'(out_valid), 1);
    @(posedge clk);
    #1;
    v = '{8'h0F, 1'b1, 2, 1'b1};
    drive(v, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_hits", int'(out_hits), 5);
      check("bp_out_last_z", int'(out_last_z), 1);
      check("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_idle", int'(busy), 0);
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_clr   = 1'b0;
    drain();

    // Reset during the third SHIFT cycle of a word that would extend a run.
    v = '{8'hF0, 1'b1, 2, 1'b1};
    send(v, 1'b1, acc);
    drain();
    v = '{8'hFF, 1'b0, 8, 1'b1};
    send(v, 1'b0, acc);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort_busy_before", int'(busy), 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    v = '{8'hFF, 1'b0, 5, 1'b1};
    send(v, 1'b1, acc);
    drain();
    check("final_count", n_popped, n_pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
